// File: rtl/fifo_drain_pkg.sv
// Shared constants for the FIFO drain arbiter: default geometry and the
// width of the source-index field.
package fifo_drain_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_NUM_FIFOS  = 4;
  localparam int DEF_MAX_BURST  = 4;

  // Source index width: at least one bit even for a two-FIFO arbiter.
  function automatic int calc_src_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_SRC_W = calc_src_w(DEF_NUM_FIFOS);

endpackage

// File: rtl/fifo_rr_picker.sv
// Combinational round-robin picker: scans the request vector starting at
// i_start and wrapping, and grants the first requester found.
module fifo_rr_picker
  import fifo_drain_pkg::*;
#(
  parameter int N     = DEF_NUM_FIFOS,
  parameter int IDX_W = calc_src_w(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_start,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  int               w_pos;
  logic [IDX_W-1:0] w_scan;

  // First requester at or after i_start, modulo N.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_pos   = 0;
    w_scan  = '0;
    for (int k = 0; k < N; k++) begin
      w_pos = int'(i_start) + k;
      if (w_pos >= N) begin
        w_pos = w_pos - N;
      end
      w_scan = IDX_W'(w_pos);
      if (!o_any && i_req[w_scan]) begin
        o_any           = 1'b1;
        o_grant[w_scan] = 1'b1;
        o_idx           = w_scan;
      end
    end
  end

endmodule

// File: rtl/fifo_drain_arbiter.sv
// Drains NUM_FIFOS show-ahead FIFOs into one valid/ready stream. A source
// keeps the grant for up to MAX_BURST consecutive beats, then the grant
// rotates to the next non-empty FIFO; a lone requester is simply re-granted
// with a fresh burst count.
module fifo_drain_arbiter
  import fifo_drain_pkg::*;
#(
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int NUM_FIFOS  = DEF_NUM_FIFOS,
  parameter  int MAX_BURST  = DEF_MAX_BURST,
  localparam int SRC_W      = calc_src_w(NUM_FIFOS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_FIFOS-1:0]            fifo_empty,
  input  logic [NUM_FIFOS*DATA_WIDTH-1:0] fifo_dout,
  output logic [NUM_FIFOS-1:0]            fifo_rd_en,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [DATA_WIDTH-1:0]           m_data,
  output logic [SRC_W-1:0]                m_src
);

  localparam int               BC_W     = $clog2(MAX_BURST + 1);
  localparam logic [BC_W-1:0]  BC_MAX   = BC_W'(MAX_BURST);
  localparam logic [BC_W-1:0]  BC_ONE   = BC_W'(1);
  localparam logic [SRC_W-1:0] LAST_IDX = SRC_W'(NUM_FIFOS - 1);

  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic [SRC_W-1:0]      r_src;
  logic [SRC_W-1:0]      r_cur;
  logic [BC_W-1:0]       r_burst_cnt;

  logic                  w_load;
  logic                  w_burst_ok;
  logic [SRC_W-1:0]      w_start;
  logic [NUM_FIFOS-1:0]  w_pick_grant;
  logic [SRC_W-1:0]      w_pick_idx;
  logic                  w_pick_any;
  logic                  w_sel_valid;
  logic [SRC_W-1:0]      w_sel_idx;
  logic [NUM_FIFOS-1:0]  w_sel_onehot;
  logic [DATA_WIDTH-1:0] w_dout_arr [NUM_FIFOS];

  for (genvar g = 0; g < NUM_FIFOS; g++) begin : g_unpack
    assign w_dout_arr[g] = fifo_dout[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // The output register may take a new beat when empty or being drained.
  assign w_load = !r_valid || m_ready;

  // Stay on the current source while its burst has room and it has data.
  assign w_burst_ok = (r_burst_cnt != '0) && (r_burst_cnt < BC_MAX) && !fifo_empty[r_cur];

  // Scan begins just after cur so that cur is the last candidate.
  assign w_start = (r_cur == LAST_IDX) ? '0 : r_cur + 1'b1;

  fifo_rr_picker #(
    .N     (NUM_FIFOS),
    .IDX_W (SRC_W)
  ) u_picker (
    .i_req   (~fifo_empty),
    .i_start (w_start),
    .o_grant (w_pick_grant),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  assign w_sel_valid  = w_load && !rst && (w_burst_ok || w_pick_any);
  assign w_sel_idx    = w_burst_ok ? r_cur : w_pick_idx;
  assign w_sel_onehot = w_burst_ok ? (NUM_FIFOS'(1) << r_cur) : w_pick_grant;
  assign fifo_rd_en   = w_sel_valid ? w_sel_onehot : '0;

  // Output beat register: capture the granted head, or go idle when nothing is selectable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_src   <= '0;
    end else if (w_load) begin
      if (w_sel_valid) begin
        r_valid <= 1'b1;
        r_data  <= w_dout_arr[w_sel_idx];
        r_src   <= w_sel_idx;
      end else begin
        r_valid <= 1'b0;
      end
    end
  end

  // Arbitration state: current owner and its burst length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cur       <= LAST_IDX;
      r_burst_cnt <= '0;
    end else if (w_load) begin
      if (w_sel_valid) begin
        if (w_burst_ok) begin
          r_burst_cnt <= r_burst_cnt + 1'b1;
        end else begin
          r_cur       <= w_sel_idx;
          r_burst_cnt <= BC_ONE;
        end
      end else begin
        r_burst_cnt <= '0;
      end
    end
  end

  assign m_valid = r_valid;
  assign m_data  = r_data;
  assign m_src   = r_src;

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Bench for fifo_drain_arbiter: FIFOs are modelled as queues, and a
// transaction-level reference decides each cycle which FIFO must be read.
module tb_fifo_drain_arbiter;

  localparam int DW = 8;
  localparam int NF = 4;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NF-1:0]   fifo_empty;
  logic [NF*DW-1:0] fifo_dout;
  logic [NF-1:0]   fifo_rd_en;
  logic            m_valid;
  logic            m_ready;
  logic [DW-1:0]   m_data;
  logic [1:0]      m_src;

  fifo_drain_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_FIFOS  (NF),
    .MAX_BURST  (MB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_src      (m_src)
  );

  always #5 clk = ~clk;

  logic [7:0] q [NF][$];
  int         acc_src [$];
  logic [7:0] acc_data [$];

  // reference: output register contents and arbitration history
  bit         m_mv;
  logic [7:0] m_md;
  int         m_msrc;
  int         m_cur;
  int         m_cnt;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_fifos();
    for (int i = 0; i < NF; i++) begin
      if (q[i].size() > 0) begin
        fifo_empty[i]          = 1'b0;
        fifo_dout[i*DW +: DW]  = q[i][0];
      end else begin
        fifo_empty[i]          = 1'b1;
        fifo_dout[i*DW +: DW]  = 8'h00;
      end
    end
  endtask

  task automatic model_reset();
    m_mv   = 1'b0;
    m_md   = 8'h00;
    m_msrc = 0;
    m_cur  = NF - 1;
    m_cnt  = 0;
  endtask

  // Which FIFO the rules say should be read next (-1: none).
  function automatic int model_sel();
    if (m_cnt > 0 && m_cnt < MB && q[m_cur].size() > 0) return m_cur;
    for (int k = 1; k <= NF; k++) begin
      if (q[(m_cur + k) % NF].size() > 0) return (m_cur + k) % NF;
    end
    return -1;
  endfunction

  task automatic cycle(input string tag, output int loaded);
    int            s;
    bit            load;
    logic [NF-1:0] e;
    drive_fifos();
    #1;
    load = !m_mv || m_ready;
    s    = model_sel();
    e    = '0;
    if (load && s >= 0) e = NF'(1) << s;
    check({tag, "_rd_en"}, 32'(fifo_rd_en), 32'(e));
    @(posedge clk);
    if (m_mv && m_ready) begin
      acc_src.push_back(m_msrc);
      acc_data.push_back(m_md);
    end
    loaded = -1;
    if (load) begin
      if (s >= 0) begin
        m_md   = q[s].pop_front();
        m_msrc = s;
        m_mv   = 1'b1;
        loaded = s;
        if (s == m_cur && m_cnt > 0 && m_cnt < MB) m_cnt++;
        else begin
          m_cur = s;
          m_cnt = 1;
        end
      end else begin
        m_mv  = 1'b0;
        m_cnt = 0;
      end
    end
    #1;
    drive_fifos();
    check({tag, "_m_valid"}, 32'(m_valid), 32'(m_mv));
    if (m_mv) begin
      check({tag, "_m_data"}, 32'(m_data), 32'(m_md));
      check({tag, "_m_src"}, 32'(m_src), 32'(m_msrc));
    end
  endtask

  task automatic start_scenario();
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < NF; i++) q[i].delete();
    acc_src.delete();
    acc_data.delete();
    m_ready = 1'b1;
    drive_fifos();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic fill(input int idx, input int cnt);
    for (int j = 0; j < cnt; j++) q[idx].push_back({4'(idx + 1), 4'(j)});
  endtask

  int dummy;
  int ld;
  int n1;
  bit reached;
  int exp_burst [17] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0};
  int exp_early [8]  = '{0,0,1,1,1,1,1,1};

  initial begin
    fifo_empty = '1;
    fifo_dout  = '0;
    m_ready    = 1'b1;

    // reset with every FIFO offering data
    start_scenario();
    rst = 1'b1;
    for (int i = 0; i < NF; i++) fill(i, 8);
    for (int c = 0; c < 2; c++) begin
      drive_fifos();
      @(posedge clk);
      #1;
      check("rst_rd_en", 32'(fifo_rd_en), 32'h0);
      check("rst_m_valid", 32'(m_valid), 32'h0);
      check("rst_m_data", 32'(m_data), 32'h0);
      check("rst_m_src", 32'(m_src), 32'h0);
    end
    rst = 1'b0;
    drive_fifos();
    #1;
    check("rst_first_grant", 32'(fifo_rd_en), 32'h1);
    for (int c = 0; c < 3; c++) cycle("post_rst", dummy);

    // single source, FIFO 2 only
    start_scenario();
    q[2].push_back(8'hA1);
    q[2].push_back(8'hA2);
    q[2].push_back(8'hA3);
    for (int c = 0; c < 5; c++) begin
      drive_fifos();
      #1;
      if (c < 3) check("single_rd_en", 32'(fifo_rd_en), 32'h4);
      cycle("single", dummy);
    end
    check("single_count", 32'(acc_src.size()), 32'd3);
    for (int k = 0; k < acc_src.size() && k < 3; k++) begin
      check("single_src", 32'(acc_src[k]), 32'd2);
      check("single_data", 32'(acc_data[k]), 32'(8'hA1 + k));
    end
    check("single_idle", 32'(m_valid), 32'h0);

    // bursts across four busy FIFOs
    start_scenario();
    for (int i = 0; i < NF; i++) fill(i, 5);
    for (int c = 0; c < 18; c++) cycle("burst", dummy);
    check("burst_count", 32'(acc_src.size()), 32'd17);
    for (int k = 0; k < 17 && k < acc_src.size(); k++) check("burst_seq", 32'(acc_src[k]), 32'(exp_burst[k]));

    // backpressure holds the beat and blocks reads
    start_scenario();
    fill(0, 3);
    fill(1, 2);
    m_ready = 1'b0;
    cycle("bp_first", dummy);
    for (int c = 0; c < 5; c++) begin
      drive_fifos();
      #1;
      check("bp_rd_en", 32'(fifo_rd_en), 32'h0);
      cycle("bp_hold", dummy);
      check("bp_valid", 32'(m_valid), 32'h1);
      check("bp_data", 32'(m_data), 32'h10);
      check("bp_src", 32'(m_src), 32'h0);
    end
    check("bp_none_taken", 32'(acc_src.size()), 32'd0);
    m_ready = 1'b1;
    cycle("bp_release", dummy);
    check("bp_accept_count", 32'(acc_src.size()), 32'd1);
    if (acc_data.size() > 0) check("bp_accept_data", 32'(acc_data[0]), 32'h10);

    // FIFO 0 runs dry early, FIFO 1 takes over and is re-granted
    start_scenario();
    fill(0, 2);
    fill(1, 6);
    for (int c = 0; c < 9; c++) cycle("early", dummy);
    check("early_count", 32'(acc_src.size()), 32'd8);
    for (int k = 0; k < 8 && k < acc_src.size(); k++) check("early_seq", 32'(acc_src[k]), 32'(exp_early[k]));
    check("early_idle", 32'(m_valid), 32'h0);

    // reset pulse while src 1's third beat sits in the output register
    start_scenario();
    for (int i = 0; i < NF; i++) fill(i, 6);
    n1 = 0;
    reached = 1'b0;
    for (int c = 0; c < 40 && !reached; c++) begin
      cycle("midrst_run", ld);
      if (ld == 1) n1++;
      if (n1 == 3) reached = 1'b1;
    end
    check("midrst_reach", 32'(reached), 32'h1);
    rst = 1'b1;
    #1;
    check("midrst_valid", 32'(m_valid), 32'h0);
    check("midrst_rd_en", 32'(fifo_rd_en), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_fifos();
    #1;
    check("midrst_first_grant", 32'(fifo_rd_en), 32'h1);
    for (int c = 0; c < 6; c++) cycle("midrst_after", dummy);

    // randomized traffic against the reference
    start_scenario();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NF; i++) begin
        if ($urandom_range(3) == 0 && q[i].size() < 8) q[i].push_back(8'($urandom));
      end
      m_ready = ($urandom_range(3) != 0);
      cycle("rand", dummy);
    end
    m_ready = 1'b1;
    for (int c = 0; c < 40; c++) cycle("drain", dummy);
    check("drain_idle", 32'(m_valid), 32'h0);
    check("drain_empty", 32'(fifo_empty), 32'hF);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
